// File: rtl/prio_pkg.sv
// Shared types and helpers for the priority encoder / round-robin arbiter.
package prio_pkg;

    typedef enum logic {
        PRIO_FIXED = 1'b0,
        PRIO_RR    = 1'b1
    } prio_mode_e;

    // Index width that stays at least one bit wide even for tiny N.
    function automatic int clog2_min1(input int n);
        int c;
        c = $clog2(n);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/prio_scan.sv
// Combinational rotating priority search: the first set bit scanning down from
// 'start' (wrapping mod N) wins.
module prio_scan
    import prio_pkg::*;
#(
    parameter  int N  = 8,
    localparam int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] idx,
    output logic          none
);

    logic [N-1:0]  rot;
    logic [IW-1:0] pos;
    logic [IW:0]   unrot;

    // Sums never exceed 2N-1 because start < N, so one conditional subtract is a full mod N.
    function automatic logic [IW-1:0] wrap(input logic [IW:0] v);
        return (v >= (IW+1)'(N)) ? IW'(v - (IW+1)'(N)) : IW'(v);
    endfunction

    // Rotate so that line 'start' lands on bit N-1, the top of the search.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            logic [IW:0] src;
            assign src     = (IW+1)'(gi) + {1'b0, start} + (IW+1)'(1);
            assign rot[gi] = req[wrap(src)];
        end
    endgenerate

    always_comb begin
        pos = '0;
        for (int j = 0; j < N; j++) begin
            if (rot[j]) pos = IW'(j);
        end
    end

    assign none  = ~|req;
    assign unrot = {1'b0, pos} + {1'b0, start} + (IW+1)'(1);
    assign idx   = none ? '0 : wrap(unrot);

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered priority encoder / arbiter with valid/ready on both sides;
// fixed priority (top index wins) or round-robin with a rotating pointer.
module prio_encoder_rr
    import prio_pkg::*;
#(
    parameter  int N    = 8,
    parameter  int MODE = 0,
    localparam int IW   = clog2_min1(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  req,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_idx,
    output logic          out_none
);

    localparam bit            RR_MODE = (MODE == int'(PRIO_RR));
    localparam logic [IW-1:0] LAST    = IW'(N - 1);

    logic          valid_reg;
    logic          none_reg;
    logic [IW-1:0] idx_reg;
    logic [IW-1:0] ptr_reg;
    logic [IW-1:0] start;
    logic [IW-1:0] scan_idx;
    logic          scan_none;
    logic          accept;

    assign start = RR_MODE ? ptr_reg : LAST;

    prio_scan #(.N(N)) u_scan (
        .req   (req),
        .start (start),
        .idx   (scan_idx),
        .none  (scan_none)
    );

    assign in_ready = !valid_reg || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= 1'b0;
            idx_reg   <= '0;
            none_reg  <= 1'b0;
            ptr_reg   <= LAST;
        end else if (accept) begin
            valid_reg <= 1'b1;
            idx_reg   <= scan_idx;
            none_reg  <= scan_none;
            // The line just granted drops to lowest priority; empty requests leave ptr alone.
            if (RR_MODE && !scan_none) begin
                ptr_reg <= (scan_idx == '0) ? LAST : scan_idx - IW'(1);
            end
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign out_valid = valid_reg;
    assign out_idx   = idx_reg;
    assign out_none  = none_reg;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: fixed N=8, round-robin N=8 and round-robin N=5 instances.
module tb_prio_encoder_rr;

    logic             clk;
    logic             reset;
    logic [2:0]       iv;
    logic [2:0]       ir;
    logic [2:0]       ov;
    logic [2:0]       ordy;
    logic [2:0]       none;
    logic [2:0][7:0]  rq;
    logic [2:0][2:0]  idx;

    int total = 0;
    int bad   = 0;

    logic [3:0] sbq[3][$];
    int         mptr[3];

    typedef struct {
        logic [7:0] req;
        int         idx;
        bit         none;
    } vec_t;

    vec_t fv[6];
    int   rr8_exp[3];
    int   rr5_req[6];
    int   rr5_exp[6];

    prio_encoder_rr #(.N(8), .MODE(0)) u_fix (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .req(rq[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_idx(idx[0]), .out_none(none[0])
    );

    prio_encoder_rr #(.N(8), .MODE(1)) u_rr8 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .req(rq[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_idx(idx[1]), .out_none(none[1])
    );

    prio_encoder_rr #(.N(5), .MODE(1)) u_rr5 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .req(rq[2][4:0]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_idx(idx[2]), .out_none(none[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nof(input int i);
        return (i == 2) ? 5 : 8;
    endfunction

    function automatic int modeof(input int i);
        return (i == 0) ? 0 : 1;
    endfunction

    // Reference: walk p, p-1, ... wrapping mod n; -1 means no request.
    function automatic int mwin(input int n, input int p, input logic [7:0] r);
        for (int k = 0; k < n; k++) begin
            if (r[3'((p - k + n) % n)]) return (p - k + n) % n;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push at accept, pop and compare at output handshake.
    always @(negedge clk) begin
        int w;
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                sbq[i].delete();
                mptr[i] = nof(i) - 1;
            end else begin
                if (ov[i]) chk($sformatf("idx_range%0d", i), int'(int'(idx[i]) < nof(i)), 1);
                if (ov[i] && ordy[i]) begin
                    chk($sformatf("sb_has_entry%0d", i), int'(sbq[i].size() > 0), 1);
                    if (sbq[i].size() > 0) begin
                        logic [3:0] e;
                        e = sbq[i].pop_front();
                        chk($sformatf("sb_idx%0d", i), int'(idx[i]), int'(e[2:0]));
                        chk($sformatf("sb_none%0d", i), int'(none[i]), int'(e[3]));
                    end
                end
                if (iv[i] && ir[i]) begin
                    w = mwin(nof(i), (modeof(i) != 0) ? mptr[i] : nof(i) - 1, rq[i]);
                    if (w < 0) begin
                        sbq[i].push_back(4'b1000);
                    end else begin
                        sbq[i].push_back({1'b0, 3'(w)});
                        if (modeof(i) != 0) mptr[i] = (w == 0) ? nof(i) - 1 : w - 1;
                    end
                end
            end
        end
    end

    initial begin
        fv[0] = '{8'b1010_0000, 7, 1'b0};
        fv[1] = '{8'b0000_0001, 0, 1'b0};
        fv[2] = '{8'b0000_0000, 0, 1'b1};
        fv[3] = '{8'b0101_0000, 6, 1'b0};
        fv[4] = '{8'b1111_1111, 7, 1'b0};
        fv[5] = '{8'b0000_0010, 1, 1'b0};
        rr8_exp = '{7, 3, 0};
        rr5_req = '{5'b00001, 5'b10001, 5'b10001, 5'b10001, 5'b10000, 5'b01000};
        rr5_exp = '{0, 4, 0, 4, 4, 3};

        reset = 1'b1;
        iv    = '0;
        ordy  = '1;
        rq    = '0;

        // Reset state
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_valid%0d", i), int'(ov[i]), 0);
            chk($sformatf("rst_idx%0d", i), int'(idx[i]), 0);
            chk($sformatf("rst_none%0d", i), int'(none[i]), 0);
        end
        tick();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("rst_in_ready%0d", i), int'(ir[i]), 1);

        // Fixed priority vectors
        for (int v = 0; v < 6; v++) begin
            iv[0] = 1'b1;
            rq[0] = fv[v].req;
            tick();
            chk($sformatf("fix_valid_v%0d", v), int'(ov[0]), 1);
            chk($sformatf("fix_idx_v%0d", v), int'(idx[0]), fv[v].idx);
            chk($sformatf("fix_none_v%0d", v), int'(none[0]), int'(fv[v].none));
        end
        iv[0] = 1'b0;
        tick();
        chk("fix_drop_valid", int'(ov[0]), 0);
        chk("fix_hold_idx", int'(idx[0]), 1);

        // Round-robin, held request, back-to-back grants
        iv[1] = 1'b1;
        rq[1] = 8'b1000_1001;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("rr8_valid_k%0d", k), int'(ov[1]), 1);
            chk($sformatf("rr8_idx_k%0d", k), int'(idx[1]), rr8_exp[k % 3]);
        end
        iv[1] = 1'b0;
        tick();

        // Backpressure: grant 7 leaves ptr=6, held while out_ready=0
        iv[1] = 1'b1;
        rq[1] = 8'b1000_1001;
        tick();
        chk("bp_first_idx", int'(idx[1]), 7);
        ordy[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rq[1] = 8'($urandom);
            tick();
            chk($sformatf("bp_hold_idx_k%0d", k), int'(idx[1]), 7);
            chk($sformatf("bp_hold_valid_k%0d", k), int'(ov[1]), 1);
            chk($sformatf("bp_in_ready_k%0d", k), int'(ir[1]), 0);
        end
        rq[1]   = 8'hFF;
        ordy[1] = 1'b1;
        tick();
        chk("bp_resume_idx", int'(idx[1]), 6);
        iv[1] = 1'b0;
        tick();

        // Round-robin, N=5
        iv[2] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            rq[2] = 8'(rr5_req[k]);
            tick();
            chk($sformatf("rr5_valid_k%0d", k), int'(ov[2]), 1);
            chk($sformatf("rr5_idx_k%0d", k), int'(idx[2]), rr5_exp[k]);
        end
        iv[2] = 1'b0;
        tick();

        // Reset mid-transfer
        iv[1] = 1'b1;
        rq[1] = 8'b1000_1001;
        tick();
        chk("mid_pre_valid", int'(ov[1]), 1);
        reset = 1'b1;
        iv    = '0;
        #1;
        chk("mid_rst_valid", int'(ov[1]), 0);
        chk("mid_rst_idx", int'(idx[1]), 0);
        chk("mid_rst_none", int'(none[1]), 0);
        tick();
        reset = 1'b0;
        #1;
        chk("mid_in_ready", int'(ir[1]), 1);
        iv[1] = 1'b1;
        rq[1] = 8'b1000_1001;
        tick();
        chk("mid_ptr_reset_idx", int'(idx[1]), 7);
        iv[1] = 1'b0;
        tick();

        // Random traffic against the scoreboard
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 3; i++) begin
                iv[i]   = ($urandom_range(0, 3) != 0);
                ordy[i] = ($urandom_range(0, 3) != 0);
                rq[i]   = ($urandom_range(0, 7) == 0) ? 8'h00
                        : (8'($urandom) & ((i == 2) ? 8'h1F : 8'hFF));
            end
            tick();
        end
        iv   = '0;
        ordy = '1;
        for (int k = 0; k < 4; k++) tick();
        for (int i = 0; i < 3; i++) chk($sformatf("drain_q%0d", i), sbq[i].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
